// File: rtl/proj_pkg.sv
// Shared constants and state types for the fragment-memory sequencer.
// Stats outputs of proj_fm_ctrl are enabled by defining PROJ_FM_CTRL_STATS_EN.
package proj_pkg;

    localparam int FM_DATA_BITS              = 2;
    localparam int FM_BUFFER_SIZE            = 16;
    localparam int FM_EXTENDER_FRAG_LEN_BITS = 8;
    localparam int SIGNED_INDICE_LEN         = 8;
    localparam int KMER_LEN                  = 8;
    localparam int FM_IDX_START              = -2;
    localparam int FM_IDX_STRIDE             = 2;
    localparam int FM_RD_LAT                 = 1;
    localparam int FM_IDX_LAST               = FM_BUFFER_SIZE * FM_DATA_BITS - FM_EXTENDER_FRAG_LEN_BITS;

    typedef enum logic [2:0] {
        FILL_IDLE      = 3'd0,
        FILL_FILL      = 3'd1,
        FILL_SETTLE    = 3'd2,
        FILL_WAIT_SWAP = 3'd3,
        FILL_SWAP      = 3'd4
    } fm_fill_state_t;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_ISSUE = 2'd1,
        SCAN_HOLD  = 2'd2
    } fm_scan_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/proj_fm_scan_idx.sv
// Signed fragment-index stepper: loads the scan start, steps by a fixed stride
// and flags the last index of a scan; one guard bit keeps the add from wrapping.
module proj_fm_scan_idx #(
    parameter int IDX_W  = 8,
    parameter int START  = -2,
    parameter int STRIDE = 2,
    parameter int LAST   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic signed [IDX_W:0] START_G  = (IDX_W + 1)'(START);
    localparam logic signed [IDX_W:0] STRIDE_G = (IDX_W + 1)'(STRIDE);
    localparam logic signed [IDX_W:0] THRESH_G = (IDX_W + 1)'(LAST - STRIDE);

    logic signed [IDX_W:0] idx_g;
    logic signed [IDX_W:0] nxt_g;
    logic                  ovf;

    assign idx_g = $signed({idx[IDX_W-1], idx});
    assign nxt_g = idx_g + STRIDE_G;
    assign ovf   = nxt_g[IDX_W] != nxt_g[IDX_W-1];
    assign last  = idx_g > THRESH_G;

    // Index register: reload on scan end/reset, advance only while not on the last fragment.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            idx <= START_G[IDX_W-1:0];
        end else if (step && !last && !ovf) begin
            idx <= nxt_g[IDX_W-1:0];
        end else begin
            idx <= idx;
        end
    end

endmodule

// File: rtl/proj_fm_ctrl.sv
// Fill/settle/swap and scan sequencer for the double-buffered fragment memory.
// Optional counters stat_buffers/stat_stall/stat_bp exist when PROJ_FM_CTRL_STATS_EN is defined.
module proj_fm_ctrl
    import proj_pkg::*;
#(
    parameter int DATA_BITS  = FM_DATA_BITS,
    parameter int BUF_WORDS  = FM_BUFFER_SIZE,
    parameter int FRAG_LEN   = FM_EXTENDER_FRAG_LEN_BITS,
    parameter int IDX_W      = SIGNED_INDICE_LEN,
    parameter int IDX_START  = FM_IDX_START,
    parameter int IDX_STRIDE = FM_IDX_STRIDE,
    parameter int SETTLE_CYC = KMER_LEN,
    parameter int RD_LAT     = FM_RD_LAT
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic [DATA_BITS-1:0] fm_wdata,
    output logic                 fm_wen,
    output logic                 fm_chg_idx,
    output logic [IDX_W-1:0]     fm_frag_idx,
    input  logic [FRAG_LEN-1:0]  fm_rdata,
    output logic                 frag_valid,
    output logic [FRAG_LEN-1:0]  frag_data,
    output logic [IDX_W-1:0]     frag_idx_o,
    output logic                 frag_last,
    input  logic                 frag_ready,
    output logic                 busy
`ifdef PROJ_FM_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_buffers,
    output logic [31:0]          stat_stall,
    output logic [31:0]          stat_bp
`endif
);

    localparam int IDX_LAST = BUF_WORDS * DATA_BITS - FRAG_LEN;
    localparam int WCNT_W   = $clog2(BUF_WORDS);
    localparam int SCNT_W   = $clog2(SETTLE_CYC + 1);
    localparam int LAT_W    = $clog2(RD_LAT + 2);

    fm_fill_state_t    fill_state, fill_next;
    fm_scan_state_t    scan_state, scan_next;
    logic [WCNT_W-1:0] wcnt;
    logic [SCNT_W-1:0] settle_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              accept;
    logic              scan_idle;
    logic              idx_load;
    logic              idx_step;
    logic              latch;
    logic              idx_last;
    logic [IDX_W-1:0]  scan_idx;

    assign in_ready    = (fill_state == FILL_FILL);
    assign accept      = in_valid && in_ready;
    assign fm_wen      = accept;
    assign fm_wdata    = accept ? in_data : {DATA_BITS{1'b0}};
    assign fm_chg_idx  = (fill_state == FILL_SWAP);
    assign scan_idle   = (scan_state == SCAN_IDLE);
    assign frag_valid  = (scan_state == SCAN_HOLD);
    assign fm_frag_idx = scan_idx;
    assign busy        = (fill_state != FILL_IDLE) || !scan_idle;

    // State registers for both FSMs.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            fill_state <= FILL_IDLE;
            scan_state <= SCAN_IDLE;
        end else begin
            fill_state <= fill_next;
            scan_state <= scan_next;
        end
    end

    // Fill FSM next state; the settle exit swaps directly when the scan is already idle.
    always_comb begin
        fill_next = fill_state;
        case (fill_state)
            FILL_IDLE:      if (in_valid) fill_next = FILL_FILL; else fill_next = FILL_IDLE;
            FILL_FILL:      if (accept && (wcnt == WCNT_W'(BUF_WORDS - 1))) fill_next = FILL_SETTLE;
                            else fill_next = FILL_FILL;
            FILL_SETTLE:    if (settle_cnt == SCNT_W'(SETTLE_CYC - 1))
                                fill_next = scan_idle ? FILL_SWAP : FILL_WAIT_SWAP;
                            else fill_next = FILL_SETTLE;
            FILL_WAIT_SWAP: if (scan_idle) fill_next = FILL_SWAP; else fill_next = FILL_WAIT_SWAP;
            FILL_SWAP:      if (in_valid) fill_next = FILL_FILL; else fill_next = FILL_IDLE;
            default:        fill_next = FILL_IDLE;
        endcase
    end

    // Word and settle counters.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wcnt       <= {WCNT_W{1'b0}};
            settle_cnt <= {SCNT_W{1'b0}};
        end else begin
            if (accept) begin
                wcnt <= (wcnt == WCNT_W'(BUF_WORDS - 1)) ? {WCNT_W{1'b0}} : wcnt + WCNT_W'(1);
            end
            settle_cnt <= (fill_state == FILL_SETTLE) ? settle_cnt + SCNT_W'(1) : {SCNT_W{1'b0}};
        end
    end

    // Scan FSM: ISSUE holds the index RD_LAT+1 cycles so registered read data is sampled.
    always_comb begin
        scan_next = scan_state;
        idx_load  = 1'b0;
        idx_step  = 1'b0;
        latch     = 1'b0;
        case (scan_state)
            SCAN_IDLE:  if (fill_state == FILL_SWAP) scan_next = SCAN_ISSUE; else scan_next = SCAN_IDLE;
            SCAN_ISSUE: if (lat_cnt == LAT_W'(RD_LAT)) begin
                            latch     = 1'b1;
                            scan_next = SCAN_HOLD;
                        end else begin
                            scan_next = SCAN_ISSUE;
                        end
            SCAN_HOLD:  if (frag_ready && idx_last) begin
                            idx_load  = 1'b1;
                            scan_next = SCAN_IDLE;
                        end else if (frag_ready) begin
                            idx_step  = 1'b1;
                            scan_next = SCAN_ISSUE;
                        end else begin
                            scan_next = SCAN_HOLD;
                        end
            default:    scan_next = SCAN_IDLE;
        endcase
    end

    // Read-latency counter and downstream fragment register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            lat_cnt    <= {LAT_W{1'b0}};
            frag_data  <= {FRAG_LEN{1'b0}};
            frag_idx_o <= {IDX_W{1'b0}};
            frag_last  <= 1'b0;
        end else begin
            lat_cnt <= (scan_state == SCAN_ISSUE) ? lat_cnt + LAT_W'(1) : {LAT_W{1'b0}};
            if (latch) begin
                frag_data  <= fm_rdata;
                frag_idx_o <= scan_idx;
                frag_last  <= idx_last;
            end
        end
    end

    proj_fm_scan_idx #(
        .IDX_W  (IDX_W),
        .START  (IDX_START),
        .STRIDE (IDX_STRIDE),
        .LAST   (IDX_LAST)
    ) u_scan_idx (
        .clk  (in_clk),
        .rst  (in_rst),
        .load (idx_load),
        .step (idx_step),
        .idx  (scan_idx),
        .last (idx_last)
    );

`ifdef PROJ_FM_CTRL_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            stat_buffers <= 32'd0;
            stat_stall   <= 32'd0;
            stat_bp      <= 32'd0;
        end else begin
            if (fill_state == FILL_SWAP) stat_buffers <= sat_inc(stat_buffers);
            if (frag_valid && !frag_ready) stat_stall <= sat_inc(stat_stall);
            if (in_valid && !in_ready) stat_bp <= sat_inc(stat_bp);
        end
    end
`endif

endmodule

// File: tb/tb_proj_fm_ctrl.sv
// Randomized bench for proj_fm_ctrl with a behavioural FM and a buffer/fragment scoreboard.
// Checks the stat_* outputs too when PROJ_FM_CTRL_STATS_EN is defined.
module tb_proj_fm_ctrl;

    localparam int START  = -2;
    localparam int STRIDE = 2;
    localparam int LAST   = 16 * 2 - 8;
    localparam int WORDS  = 16;

    logic       clk = 1'b0;
    logic       in_rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'd0;
    logic       in_ready;
    logic [1:0] fm_wdata;
    logic       fm_wen;
    logic       fm_chg_idx;
    logic [7:0] fm_frag_idx;
    logic [7:0] fm_rdata = 8'd0;
    logic       frag_valid;
    logic [7:0] frag_data;
    logic [7:0] frag_idx_o;
    logic       frag_last;
    logic       frag_ready = 1'b1;
    logic       busy;
`ifdef PROJ_FM_CTRL_STATS_EN
    logic [31:0] stat_buffers, stat_stall, stat_bp;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    proj_fm_ctrl dut (
        .in_clk      (clk),
        .in_rst      (in_rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .fm_wdata    (fm_wdata),
        .fm_wen      (fm_wen),
        .fm_chg_idx  (fm_chg_idx),
        .fm_frag_idx (fm_frag_idx),
        .fm_rdata    (fm_rdata),
        .frag_valid  (frag_valid),
        .frag_data   (frag_data),
        .frag_idx_o  (frag_idx_o),
        .frag_last   (frag_last),
        .frag_ready  (frag_ready),
        .busy        (busy)
`ifdef PROJ_FM_CTRL_STATS_EN
        ,
        .stat_buffers (stat_buffers),
        .stat_stall   (stat_stall),
        .stat_bp      (stat_bp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Fragment of a 32-bit buffer image starting at signed bit index idx; outside bits read 0.
    function automatic logic [7:0] frag_of(input logic [31:0] img, input logic [7:0] idx);
        logic [7:0] r;
        int base;
        base = int'($signed(idx));
        for (int b = 0; b < 8; b++) begin
            r[b] = ((base + b >= 0) && (base + b < 32)) ? img[base + b] : 1'b0;
        end
        return r;
    endfunction

    // Behavioural double-buffered FM with one-cycle registered read.
    logic [31:0] fm_wimg = 32'd0;
    logic [31:0] fm_rimg = 32'd0;
    logic [3:0]  fm_wptr = 4'd0;
    always @(posedge clk) begin
        if (in_rst) begin
            fm_wptr <= 4'd0;
        end else begin
            if (fm_wen) begin
                fm_wimg[int'(fm_wptr) * 2 +: 2] <= fm_wdata;
                fm_wptr <= fm_wptr + 4'd1;
            end
            if (fm_chg_idx) fm_rimg <= fm_wimg;
        end
        fm_rdata <= frag_of(fm_rimg, fm_frag_idx);
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // frag_ready pattern generator: 0 always ready, 1 toggle, 2 random.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       frag_ready = 1'b1;
            1:       frag_ready = ~frag_ready;
            default: frag_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard state (written only by the monitor below).
    logic [1:0]  acc_q[$];
    logic [31:0] buf_img_q[$];
    int          buf_cyc_q[$];
    logic [7:0]  exp_idx_q[$];
    logic [7:0]  exp_data_q[$];
    logic        exp_last_q[$];
    int          last_scan_end = -100;
    int          six_seen = 0;
    int          m_buf = 0, m_stall = 0, m_bp = 0;
    bit          held = 1'b0;
    logic [16:0] held_val;

    initial forever begin
        @(negedge clk);
        if (in_rst) begin
            acc_q.delete(); buf_img_q.delete(); buf_cyc_q.delete();
            exp_idx_q.delete(); exp_data_q.delete(); exp_last_q.delete();
            last_scan_end = -100;
            held = 1'b0;
            m_buf = 0; m_stall = 0; m_bp = 0;
        end else begin
            if (held) begin
                chk("frag_stable", {frag_valid, frag_data, frag_idx_o, frag_last}, {1'b1, held_val[16:0]});
                held = 1'b0;
            end
            if (frag_valid && !frag_ready) begin
                held = 1'b1;
                held_val = {frag_data, frag_idx_o, frag_last};
                m_stall++;
            end
            if (frag_valid) chk("busy_scan", busy, 1);
            if (in_valid && !in_ready) m_bp++;
            if (in_valid || fm_wen) chk("wen", fm_wen, in_valid & in_ready);
            if (in_valid && buf_img_q.size() > 0) chk("bp_hold", in_ready, 0);
            if (in_valid && in_ready) begin
                chk("wdata", fm_wdata, in_data);
                acc_q.push_back(in_data);
                if (acc_q.size() == WORDS) begin
                    logic [31:0] img;
                    for (int k = 0; k < WORDS; k++) img[2 * k +: 2] = acc_q[k];
                    buf_img_q.push_back(img);
                    buf_cyc_q.push_back(cyc);
                    acc_q.delete();
                end
            end
            if (fm_chg_idx) begin
                chk("chg_rdy", in_ready, 0);
                chk("chg_has_buf", buf_img_q.size() > 0, 1);
                if (buf_img_q.size() > 0) begin
                    int exp_c;
                    logic [31:0] img;
                    int ix;
                    bit lst;
                    chk("chg_mid_scan", exp_idx_q.size(), 0);
                    exp_c = buf_cyc_q[0] + 9;
                    if (last_scan_end + 2 > exp_c) exp_c = last_scan_end + 2;
                    chk("chg_time", cyc, exp_c);
                    img = buf_img_q.pop_front();
                    void'(buf_cyc_q.pop_front());
                    m_buf++;
                    ix = START;
                    do begin
                        lst = (ix > LAST - STRIDE);
                        exp_idx_q.push_back(8'(ix));
                        exp_data_q.push_back(frag_of(img, 8'(ix)));
                        exp_last_q.push_back(lst);
                        ix += STRIDE;
                    end while (!lst);
                end
            end
            if (frag_valid && frag_ready) begin
                if (exp_idx_q.size() == 0) begin
                    chk("frag_extra", 1, 0);
                end else begin
                    chk("frag_idx", frag_idx_o, exp_idx_q.pop_front());
                    chk("frag_data", frag_data, exp_data_q.pop_front());
                    chk("frag_last", frag_last, exp_last_q.pop_front());
                    if (frag_last) last_scan_end = cyc;
                    if (frag_idx_o == 8'd6) six_seen++;
                end
            end
        end
    end

    task automatic reset_dut();
        in_rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_rst = 1'b0;
    endtask

    task automatic send(input int n, input int gap);
        bit acc;
        int t;
        int g;
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = 2'($urandom);
            t = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 2000);
            if (!acc) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            ok = !busy && exp_idx_q.size() == 0 && buf_img_q.size() == 0;
        end
        chk("drain", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef PROJ_FM_CTRL_STATS_EN
        chk({tag, "_stat_buf"}, stat_buffers, m_buf);
        chk({tag, "_stat_stall"}, stat_stall, m_stall);
        chk({tag, "_stat_bp"}, stat_bp, m_bp);
`else
        chk({tag, "_quiet"}, {frag_valid, fm_chg_idx, fm_wen}, 3'd0);
`endif
    endtask

    initial begin
        int six0;
        int t;
        reset_dut();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wen", fm_wen, 0);
        chk("rst_wdata", fm_wdata, 0);
        chk("rst_chg", fm_chg_idx, 0);
        chk("rst_frag_idx", fm_frag_idx, 8'hFE);
        chk("rst_frag_valid", frag_valid, 0);
        chk("rst_frag_data", frag_data, 0);
        chk("rst_frag_idx_o", frag_idx_o, 0);
        chk("rst_frag_last", frag_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        send(16, 0);
        wait_idle(2000);
        check_stats("t1");

        send(32, 0);
        wait_idle(3000);

        reset_dut();
        rdy_mode = 1;
        send(16, 0);
        wait_idle(2000);
        check_stats("t3");
`ifdef PROJ_FM_CTRL_STATS_EN
        chk("t3_stat_buf_one", stat_buffers, 1);
`endif

        rdy_mode = 0;
        send(16, 2);
        wait_idle(2000);

        six0 = six_seen;
        send(16, 0);
        t = 0;
        while (six_seen == six0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("saw_idx6", six_seen != six0, 1);
        @(posedge clk);
        #1;
        in_rst = 1'b1;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        @(negedge clk);
        chk("mrst_frag_valid", frag_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_frag_idx", fm_frag_idx, 8'hFE);
        chk("mrst_chg", fm_chg_idx, 0);
        @(posedge clk);
        #1;
        send(16, 0);
        wait_idle(2000);

        rdy_mode = 2;
        send(48, -1);
        wait_idle(4000);
        rdy_mode = 0;
        check_stats("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
